// File: rtl/ddr2_traffic_gen.sv
// ddr2_traffic_gen: burst traffic generator and read-data checker placed in
// front of the DDR2 controller's user-side write/read master pair. It issues
// programmable bursts of incrementing data and verifies the read-back stream.
module ddr2_traffic_gen #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8,
  parameter int GAP_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            cfg_mode,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic [CNT_WIDTH-1:0]  cfg_num,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  output logic                  wr_trig,
  output logic [LEN_WIDTH-1:0]  wr_len,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_data_en,
  input  logic                  wr_ready,
  input  logic                  wr_done,
  output logic                  rd_trig,
  output logic [LEN_WIDTH-1:0]  rd_len,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_ready,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_data_en,
  input  logic                  rd_done,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  burst_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  proto_err
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_GAP, ST_WR_REQ, ST_WR_WAIT, ST_RD_REQ, ST_RD_WAIT, ST_FIN
  } state_t;

  state_t                state, state_n;

  logic [1:0]            mode_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [GAP_WIDTH-1:0]  gap_q;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [GAP_WIDTH-1:0]  gap_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] exp_q;
  logic [DATA_WIDTH-1:0] snap_q;
  logic [LEN_WIDTH:0]    beat_cnt;
  logic [CNT_WIDTH-1:0]  pass_cnt;
  logic                  rd_phase;
  logic                  stop_pend;

  logic                  start_ok;
  logic                  stop_now;
  logic                  pair_open;
  logic                  beat_en;
  logic [LEN_WIDTH:0]    beats_now;
  logic                  wr_end;
  logic                  rd_end;
  logic                  last_pass;

  // Error counter must stick at all-ones rather than wrap back to zero.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign start_ok  = (state == ST_IDLE) && start && init_end;
  assign stop_now  = stop || stop_pend;
  // In interleaved mode a write without its read-back is incomplete, so a
  // stop is held off until the read of the pair finishes.
  assign pair_open = (mode_q == 2'd3) && rd_phase;
  assign beat_en   = ((state == ST_WR_WAIT) && wr_data_en) ||
                     ((state == ST_RD_WAIT) && rd_data_en);
  assign beats_now = beat_cnt + (LEN_WIDTH+1)'(beat_en);
  assign wr_end    = (state == ST_WR_WAIT) && wr_done;
  assign rd_end    = (state == ST_RD_WAIT) && rd_done;
  assign last_pass = (num_q != '0) && ((pass_cnt + 1'b1) == num_q);

  assign wr_addr = addr_q;
  assign rd_addr = addr_q;
  assign wr_len  = len_q;
  assign rd_len  = len_q;
  assign wr_data = wdata_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state selection: gap, request handshake, wait for burst completion.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (start_ok) state_n = ST_GAP;
      ST_GAP: begin
        if (stop_now && !pair_open) state_n = ST_FIN;
        else if (gap_cnt == '0)     state_n = rd_phase ? ST_RD_REQ : ST_WR_REQ;
      end
      ST_WR_REQ:  if (wr_trig && wr_ready) state_n = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (wr_done) begin
          if ((mode_q == 2'd3) || ((mode_q == 2'd2) && last_pass && !stop_now))
            state_n = ST_GAP;
          else
            state_n = (stop_now || last_pass) ? ST_FIN : ST_GAP;
        end
      end
      ST_RD_REQ:  if (rd_trig && rd_ready) state_n = ST_RD_WAIT;
      ST_RD_WAIT: if (rd_done) state_n = (stop_now || last_pass) ? ST_FIN : ST_GAP;
      ST_FIN:     state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Registered handshake and run-status flags, derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_trig <= 1'b0;
      rd_trig <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      wr_trig <= (state_n == ST_WR_REQ);
      rd_trig <= (state_n == ST_RD_REQ);
      busy    <= (state_n != ST_IDLE) && (state_n != ST_FIN);
      done    <= (state_n == ST_FIN);
    end
  end

  // Configuration latch, address/pattern sequencing, read check and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q         <= '0;
      len_q          <= '0;
      gap_q          <= '0;
      num_q          <= '0;
      base_q         <= '0;
      gap_cnt        <= '0;
      addr_q         <= '0;
      wdata_q        <= DATA_WIDTH'(1);
      exp_q          <= DATA_WIDTH'(1);
      snap_q         <= DATA_WIDTH'(1);
      beat_cnt       <= '0;
      pass_cnt       <= '0;
      rd_phase       <= 1'b0;
      stop_pend      <= 1'b0;
      burst_cnt      <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      proto_err      <= 1'b0;
    end else if (start_ok) begin
      mode_q         <= cfg_mode;
      len_q          <= (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
      gap_q          <= cfg_gap;
      num_q          <= ((cfg_mode == 2'd2) && (cfg_num == '0)) ? CNT_WIDTH'(1) : cfg_num;
      base_q         <= cfg_base;
      gap_cnt        <= cfg_gap;
      addr_q         <= cfg_base;
      wdata_q        <= DATA_WIDTH'(1);
      exp_q          <= DATA_WIDTH'(1);
      snap_q         <= DATA_WIDTH'(1);
      beat_cnt       <= '0;
      pass_cnt       <= '0;
      rd_phase       <= (cfg_mode == 2'd1);
      stop_pend      <= 1'b0;
      burst_cnt      <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      proto_err      <= 1'b0;
    end else begin
      if (state == ST_FIN)                    stop_pend <= 1'b0;
      else if ((state != ST_IDLE) && stop)    stop_pend <= 1'b1;

      if ((state_n == ST_GAP) && (state != ST_GAP))  gap_cnt <= gap_q;
      else if ((state == ST_GAP) && (gap_cnt != '0)) gap_cnt <= gap_cnt - 1'b1;

      if ((state != ST_IDLE) && wr_data_en) wdata_q <= wdata_q + 1'b1;

      if ((state == ST_GAP) && (state_n == ST_WR_REQ)) snap_q <= wdata_q;

      if ((state == ST_WR_REQ) || (state == ST_RD_REQ)) beat_cnt <= '0;
      else if (beat_en)                                 beat_cnt <= beats_now;

      if ((state == ST_RD_WAIT) && rd_data_en) begin
        exp_q <= exp_q + 1'b1;
        if (rd_data != exp_q) begin
          err_cnt <= sat_inc(err_cnt);
          if (err_cnt == '0) first_err_addr <= addr_q;
        end
      end

      if (wr_end || rd_end) begin
        if (beats_now != {1'b0, len_q}) proto_err <= 1'b1;
        if (wr_end && (mode_q == 2'd3)) begin
          rd_phase <= 1'b1;
          exp_q    <= snap_q;
        end else if (wr_end && (mode_q == 2'd2) && last_pass) begin
          addr_q    <= base_q;
          exp_q     <= DATA_WIDTH'(1);
          pass_cnt  <= '0;
          rd_phase  <= 1'b1;
          burst_cnt <= burst_cnt + 1'b1;
        end else begin
          addr_q    <= addr_q + ADDR_WIDTH'({len_q, 1'b0});
          burst_cnt <= burst_cnt + 1'b1;
          pass_cnt  <= pass_cnt + 1'b1;
          if (mode_q == 2'd3) rd_phase <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr2_traffic_gen.sv
// Directed testbench for ddr2_traffic_gen with a simple write/read master
// responder and an echo memory for read-back traffic.
module tb_ddr2_traffic_gen;
  localparam int AW = 27, DW = 16, LW = 8, GW = 16, CW = 16;

  logic          clk = 1'b0, rst = 1'b1, init_end = 1'b0, start = 1'b0, stop = 1'b0;
  logic [1:0]    cfg_mode = '0;
  logic [LW-1:0] cfg_len = '0;
  logic [GW-1:0] cfg_gap = '0;
  logic [CW-1:0] cfg_num = '0;
  logic [AW-1:0] cfg_base = '0;
  logic          wr_trig, wr_data_en = 1'b0, wr_ready = 1'b0, wr_done = 1'b0;
  logic [LW-1:0] wr_len, rd_len;
  logic [AW-1:0] wr_addr, rd_addr, first_err_addr;
  logic [DW-1:0] wr_data, rd_data = '0;
  logic          rd_trig, rd_ready = 1'b0, rd_data_en = 1'b0, rd_done = 1'b0;
  logic          busy, done, proto_err;
  logic [CW-1:0] burst_cnt, err_cnt;

  ddr2_traffic_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
                     .GAP_WIDTH(GW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .init_end(init_end), .start(start), .stop(stop),
    .cfg_mode(cfg_mode), .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_num(cfg_num),
    .cfg_base(cfg_base), .wr_trig(wr_trig), .wr_len(wr_len), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_data_en(wr_data_en), .wr_ready(wr_ready), .wr_done(wr_done),
    .rd_trig(rd_trig), .rd_len(rd_len), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_en(rd_data_en), .rd_done(rd_done), .busy(busy),
    .done(done), .burst_cnt(burst_cnt), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int            passed = 0, total = 0, failed = 0;
  int            wait_cyc;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_first, b_last;
  logic [DW-1:0] mem [int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_trig(input bit rd, input string tag);
    wait_cyc = 0;
    while (((rd ? rd_trig : wr_trig) !== 1'b1) && (wait_cyc < 3000)) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk({tag, " trig seen"}, rd ? rd_trig : wr_trig, 1);
  endtask

  task automatic start_run(input logic [1:0] m, input int len, input int gap,
                           input int num, input logic [AW-1:0] base);
    cfg_mode = m; cfg_len = LW'(len); cfg_gap = GW'(gap); cfg_num = CW'(num);
    cfg_base = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wr_burst(input int beats, input int rdy_dly, input int stop_at,
                          input string tag);
    wait_trig(1'b0, tag);
    b_addr = wr_addr;
    repeat (rdy_dly) @(negedge clk);
    chk({tag, " trig held"}, wr_trig, 1);
    wr_ready = 1'b1;
    @(negedge clk);
    wr_ready = 1'b0;
    chk({tag, " trig cleared"}, wr_trig, 0);
    for (int i = 0; i < beats; i++) begin
      if (i == 0) b_first = wr_data;
      b_last = wr_data;
      mem[int'(b_addr) + 2*i] = wr_data;
      wr_data_en = 1'b1;
      stop = (i == stop_at);
      @(negedge clk);
    end
    wr_data_en = 1'b0;
    stop = 1'b0;
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
  endtask

  task automatic rd_burst(input int beats, input int rdy_dly, input int bad_beat,
                          input string tag);
    wait_trig(1'b1, tag);
    b_addr = rd_addr;
    repeat (rdy_dly) @(negedge clk);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    chk({tag, " rd trig cleared"}, rd_trig, 0);
    for (int i = 0; i < beats; i++) begin
      rd_data = mem[int'(b_addr) + 2*i] ^ ((i == bad_beat) ? 16'h0040 : 16'h0000);
      rd_data_en = 1'b1;
      @(negedge clk);
    end
    rd_data_en = 1'b0;
    rd_data = '0;
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst wr_data", wr_data, 1);
    chk("rst wr_trig", wr_trig, 0);
    chk("rst rd_trig", rd_trig, 0);
    chk("rst busy", busy, 0);
    chk("rst burst_cnt", burst_cnt, 0);
    chk("rst wr_addr", wr_addr, 0);
    rst = 1'b0;
    init_end = 1'b1;
    @(negedge clk);

    // Mode 0: three write bursts, long gap, delayed ready
    start_run(2'd0, 16, 90, 3, '0);
    chk("t1 busy", busy, 1);
    for (int b = 0; b < 3; b++) begin
      wr_burst(16, 2, -1, "t1");
      chk("t1 gap length", (wait_cyc >= 90) && (wait_cyc <= 92), 1);
      chk("t1 addr", b_addr, 32*b);
      chk("t1 first data", b_first, 16*b + 1);
      chk("t1 last data", b_last, 16*b + 16);
    end
    chk("t1 wr_len", wr_len, 16);
    chk("t1 done", done, 1);
    chk("t1 busy end", busy, 0);
    chk("t1 burst_cnt", burst_cnt, 3);
    chk("t1 err_cnt", err_cnt, 0);
    @(negedge clk);
    chk("t1 done pulse", done, 0);

    // Mode 2: write-all then read-all with echo memory
    start_run(2'd2, 8, 3, 2, '0);
    wr_burst(8, 1, -1, "t2w0");
    chk("t2 wr addr0", b_addr, 0);
    chk("t2 wr first", b_first, 1);
    wr_burst(8, 1, -1, "t2w1");
    chk("t2 wr addr1", b_addr, 16);
    chk("t2 wr last", b_last, 16);
    rd_burst(8, 0, -1, "t2r0");
    chk("t2 rd addr0", b_addr, 0);
    rd_burst(8, 0, -1, "t2r1");
    chk("t2 rd addr1", b_addr, 16);
    chk("t2 done", done, 1);
    chk("t2 err_cnt", err_cnt, 0);
    chk("t2 proto_err", proto_err, 0);
    @(negedge clk);

    // Mode 3: interleaved pairs, one corrupted read beat in pair 2
    start_run(2'd3, 4, 2, 3, '0);
    for (int p = 0; p < 3; p++) begin
      wr_burst(4, 1, -1, "t3w");
      chk("t3 wr addr", b_addr, 8*p);
      rd_burst(4, 1, (p == 1) ? 2 : -1, "t3r");
      chk("t3 rd addr", b_addr, 8*p);
      chk("t3 err so far", err_cnt, (p == 0) ? 0 : 1);
    end
    chk("t3 done", done, 1);
    chk("t3 err_cnt", err_cnt, 1);
    chk("t3 first_err_addr", first_err_addr, 8);
    chk("t3 burst_cnt", burst_cnt, 3);
    @(negedge clk);

    // Mode 0, endless run: stop during burst 5
    start_run(2'd0, 4, 2, 0, '0);
    for (int b = 0; b < 5; b++) wr_burst(4, 0, (b == 4) ? 1 : -1, "t4");
    chk("t4 done", done, 1);
    chk("t4 burst_cnt", burst_cnt, 5);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_trig) seen++;
    end
    chk("t4 no 6th trig", seen, 0);
    chk("t4 busy", busy, 0);

    // Short burst flags protocol error, which stays set
    start_run(2'd0, 8, 2, 2, '0);
    wr_burst(7, 0, -1, "t5a");
    chk("t5 proto set", proto_err, 1);
    wr_burst(8, 0, -1, "t5a");
    chk("t5 proto sticky", proto_err, 1);
    chk("t5 done", done, 1);
    @(negedge clk);

    // Address wrap at the top of the address space
    start_run(2'd0, 16, 2, 2, 27'h7FF_FFF0);
    chk("t5 proto cleared", proto_err, 0);
    wr_burst(16, 0, -1, "t5b");
    chk("t5 wrap addr0", b_addr, 27'h7FF_FFF0);
    wr_burst(16, 0, -1, "t5b");
    chk("t5 wrap addr1", b_addr, 16);
    @(negedge clk);

    // Zero length latched as one; reset drops an outstanding request
    start_run(2'd0, 0, 0, 0, '0);
    wait_trig(1'b0, "t6");
    chk("t6 len0 as 1", wr_len, 1);
    rst = 1'b1;
    #1;
    chk("t6 rst trig", wr_trig, 0);
    chk("t6 rst busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    init_end = 1'b0;
    start_run(2'd0, 4, 0, 0, '0);
    repeat (5) @(negedge clk);
    chk("t6 start ignored busy", busy, 0);
    chk("t6 start ignored trig", wr_trig, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
